// File: rtl/argon_regfile_seq.sv
// Micro-sequencer that runs one rc = ra FUNC rb operation against an external register file.
// Optional condition flags output o_flags is built when ARGON_SEQ_FLAGS_EN is defined.
module argon_regfile_seq #(
   parameter int WIDTH = 16,
   parameter int IDX_W = 4
) (
   input  logic             i_Clk,
   input  logic             i_Reset_n,
   input  logic             i_op_valid,
   output logic             o_op_ready,
   input  logic [IDX_W-1:0] i_op_ra,
   input  logic [IDX_W-1:0] i_op_rb,
   input  logic [IDX_W-1:0] i_op_rc,
   input  logic [2:0]       i_op_func,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result,
   output logic             o_selectLatch,
   output logic             o_outputA,
   output logic             o_outputB,
   output logic             o_latchC,
   output logic             o_bus_drive,
   output logic [WIDTH-1:0] o_bus_data,
   input  logic [WIDTH-1:0] i_bus_data,
`ifdef ARGON_SEQ_FLAGS_EN
   output logic [3:0]       o_flags,
`endif
   output logic [2:0]       o_dbg_state
);

   // Handshake: an op is accepted on a rising edge where i_op_valid and o_op_ready
   // are both high; o_op_ready is high only while idle and requests never queue.

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SEL  = 3'd1,
      S_RDA  = 3'd2,
      S_RDB  = 3'd3,
      S_CAPB = 3'd4,
      S_WR   = 3'd5
   } state_t;

   localparam logic [2:0] F_ADD = 3'd0;
   localparam logic [2:0] F_SUB = 3'd1;
   localparam logic [2:0] F_AND = 3'd2;
   localparam logic [2:0] F_OR  = 3'd3;
   localparam logic [2:0] F_XOR = 3'd4;
   localparam logic [2:0] F_SHL = 3'd5;
   localparam logic [2:0] F_SHR = 3'd6;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
   logic [2:0]         func_q, func_d;
   logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   alu_res;
   logic [WIDTH-1:0]   sel_word;
`ifdef ARGON_SEQ_FLAGS_EN
   logic [3:0]         flags_q, flags_d;
   logic               c_flag, v_flag;
`endif

   // The carry/borrow/shifted-out bit falls out of a WIDTH+1 wide operation.
   always_comb begin
      alu_res = '0;
`ifdef ARGON_SEQ_FLAGS_EN
      c_flag = 1'b0;
      v_flag = 1'b0;
`endif
      case (func_q)
`ifdef ARGON_SEQ_FLAGS_EN
         F_ADD: {c_flag, alu_res} = {1'b0, opa_q} + {1'b0, opb_q};
         F_SUB: {c_flag, alu_res} = {1'b0, opa_q} - {1'b0, opb_q};
         F_SHL: {c_flag, alu_res} = {1'b0, opa_q} << opb_q[3:0];
         F_SHR: {alu_res, c_flag} = {opa_q, 1'b0} >> opb_q[3:0];
`else
         F_ADD: alu_res = opa_q + opb_q;
         F_SUB: alu_res = opa_q - opb_q;
         F_SHL: alu_res = opa_q << opb_q[3:0];
         F_SHR: alu_res = opa_q >> opb_q[3:0];
`endif
         F_AND: alu_res = opa_q & opb_q;
         F_OR:  alu_res = opa_q | opb_q;
         F_XOR: alu_res = opa_q ^ opb_q;
         default: alu_res = opa_q;
      endcase
`ifdef ARGON_SEQ_FLAGS_EN
      if (func_q == F_ADD)
         v_flag = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (alu_res[WIDTH-1] != opa_q[WIDTH-1]);
      else if (func_q == F_SUB)
         v_flag = (opa_q[WIDTH-1] != opb_q[WIDTH-1]) && (alu_res[WIDTH-1] != opa_q[WIDTH-1]);
`endif
   end

   always_comb begin
      sel_word = '0;
      sel_word[3*IDX_W-1:0] = {rc_q, rb_q, ra_q};
   end

   always_comb begin
      state_d  = state_q;
      ra_d     = ra_q;
      rb_d     = rb_q;
      rc_d     = rc_q;
      func_d   = func_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      result_d = result_q;
      done_d   = 1'b0;
`ifdef ARGON_SEQ_FLAGS_EN
      flags_d  = flags_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (i_op_valid) begin
               ra_d    = i_op_ra;
               rb_d    = i_op_rb;
               rc_d    = i_op_rc;
               func_d  = i_op_func;
               state_d = S_SEL;
            end
         end
         S_SEL:  state_d = S_RDA;
         S_RDA:  state_d = S_RDB;
         // The regfile presents A during RDB and B during CAPB.
         S_RDB: begin
            opa_d   = i_bus_data;
            state_d = S_CAPB;
         end
         S_CAPB: begin
            opb_d   = i_bus_data;
            state_d = S_WR;
         end
         S_WR: begin
            result_d = alu_res;
            done_d   = 1'b1;
`ifdef ARGON_SEQ_FLAGS_EN
            flags_d  = {(alu_res == '0), alu_res[WIDTH-1], c_flag, v_flag};
`endif
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q  <= S_IDLE;
         ra_q     <= '0;
         rb_q     <= '0;
         rc_q     <= '0;
         func_q   <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
`ifdef ARGON_SEQ_FLAGS_EN
         flags_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         ra_q     <= ra_d;
         rb_q     <= rb_d;
         rc_q     <= rc_d;
         func_q   <= func_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         result_q <= result_d;
         done_q   <= done_d;
`ifdef ARGON_SEQ_FLAGS_EN
         flags_q  <= flags_d;
`endif
      end
   end

   // Strobes decode straight from state so an async reset kills them at once.
   always_comb begin
      o_bus_data = '0;
      if (state_q == S_SEL)
         o_bus_data = sel_word;
      else if (state_q == S_WR)
         o_bus_data = alu_res;
   end

   assign o_op_ready    = (state_q == S_IDLE);
   assign o_selectLatch = (state_q == S_SEL);
   assign o_outputA     = (state_q == S_RDA);
   assign o_outputB     = (state_q == S_RDB);
   assign o_latchC      = (state_q == S_WR);
   assign o_bus_drive   = (state_q == S_SEL) || (state_q == S_WR);
   assign o_done        = done_q;
   assign o_result      = result_q;
   assign o_dbg_state   = state_q;
`ifdef ARGON_SEQ_FLAGS_EN
   assign o_flags       = flags_q;
`endif

endmodule

// File: tb/tb_argon_regfile_seq.sv
// Bench for argon_regfile_seq: behavioural regfile, op driver, queue scoreboard and monitor.
module tb_argon_regfile_seq;

   localparam int W = 16;
   localparam logic [2:0] F_ADD = 3'd0, F_SUB = 3'd1, F_AND = 3'd2, F_OR = 3'd3;
   localparam logic [2:0] F_XOR = 3'd4, F_SHL = 3'd5, F_SHR = 3'd6, F_PASS = 3'd7;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         op_valid = 1'b0;
   logic [3:0]   op_ra = '0, op_rb = '0, op_rc = '0;
   logic [2:0]   op_func = '0;
   logic         o_op_ready, o_done, o_selectLatch, o_outputA, o_outputB, o_latchC, o_bus_drive;
   logic [W-1:0] o_result, o_bus_data;
   logic [W-1:0] rd_q = '0;
   logic [2:0]   dbg_state;
`ifdef ARGON_SEQ_FLAGS_EN
   logic [3:0]   flags;
`endif

   argon_regfile_seq #(.WIDTH(W), .IDX_W(4)) dut (
      .i_Clk(clk), .i_Reset_n(rst_n), .i_op_valid(op_valid), .o_op_ready(o_op_ready),
      .i_op_ra(op_ra), .i_op_rb(op_rb), .i_op_rc(op_rc), .i_op_func(op_func),
      .o_done(o_done), .o_result(o_result), .o_selectLatch(o_selectLatch),
      .o_outputA(o_outputA), .o_outputB(o_outputB), .o_latchC(o_latchC),
      .o_bus_drive(o_bus_drive), .o_bus_data(o_bus_data), .i_bus_data(rd_q),
`ifdef ARGON_SEQ_FLAGS_EN
      .o_flags(flags),
`endif
      .o_dbg_state(dbg_state)
   );

   // clock / reset / cycle counter
   always #5 clk = ~clk;
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // behavioural register file: r0 reads 0 and ignores writes
   logic [W-1:0] regs [16] = '{1: 16'h0005, 2: 16'h0007, 4: 16'hBEEF, 7: 16'h0001,
                               8: 16'h8001, 9: 16'h0004, 10: 16'h000F,
                               11: 16'hF0F0, 12: 16'h0FF0, default: 16'h0000};
   logic [3:0] ia = '0, ib = '0, ic = '0;
   always @(posedge clk) begin
      if (o_selectLatch) {ic, ib, ia} <= o_bus_data[11:0];
      if (o_outputA) rd_q <= (ia == 4'd0) ? '0 : regs[ia];
      if (o_outputB) rd_q <= (ib == 4'd0) ? '0 : regs[ib];
      if (o_latchC && ic != 4'd0) regs[ic] <= o_bus_data;
   end

   // scoreboard
   int n_cmp = 0, n_err = 0;
   logic [W-1:0] exp_q[$], exp_sel_q[$], exp_wr_q[$];
   logic [3:0]   exp_f_q[$];
   int unsigned  exp_dcyc_q[$], exp_wcyc_q[$];
   bit           hold = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic note_fail(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (!o_bus_drive) check("bus_zero_when_idle", o_bus_data, 0);
         check("strobes_onehot", ($countones({o_selectLatch, o_outputA, o_outputB, o_latchC}) <= 1), 1);
         if (o_selectLatch) begin
            if (exp_sel_q.size() == 0) note_fail("unexpected_select");
            else begin
               check("sel_bus", o_bus_data, exp_sel_q.pop_front());
               check("sel_drive", o_bus_drive, 1);
            end
         end
         if (o_latchC) begin
            if (exp_wr_q.size() == 0) note_fail("unexpected_latchC");
            else begin
               check("wr_bus", o_bus_data, exp_wr_q.pop_front());
               check("wr_cycle", cyc, exp_wcyc_q.pop_front());
               check("wr_drive", o_bus_drive, 1);
            end
         end
         if (o_done) begin
            if (exp_q.size() == 0) note_fail("unexpected_done");
            else begin
               check("result", o_result, exp_q.pop_front());
               check("done_cycle", cyc, exp_dcyc_q.pop_front());
`ifdef ARGON_SEQ_FLAGS_EN
               check("flags", flags, exp_f_q.pop_front());
`endif
            end
         end
      end
   end

   // driver
   task automatic issue(input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc,
                        input logic [2:0] fn, input logic [W-1:0] res, input logic [3:0] fl,
                        input bit want_done, output int unsigned acc_cyc);
      int k = 0;
      @(negedge clk);
      while (!o_op_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!o_op_ready) note_fail("ready_timeout");
      op_ra = ra; op_rb = rb; op_rc = rc; op_func = fn; op_valid = 1'b1;
      acc_cyc = cyc;
      exp_sel_q.push_back({4'h0, rc, rb, ra});
      if (want_done) begin
         exp_q.push_back(res);
         exp_f_q.push_back(fl);
         exp_wr_q.push_back(res);
         exp_wcyc_q.push_back(acc_cyc + 5);
         exp_dcyc_q.push_back(acc_cyc + 6);
      end
      @(negedge clk);
      op_ra = 4'($urandom_range(0, 15));
      op_rb = 4'($urandom_range(0, 15));
      op_rc = 4'($urandom_range(0, 15));
      op_func = 3'($urandom_range(0, 7));
      if (!hold) op_valid = 1'b0;
   endtask

   initial begin
      int unsigned a0, a1, a2, t;
      int k;
      repeat (3) @(negedge clk);
      check("rst_ready", o_op_ready, 1);
      check("rst_done", o_done, 0);
      check("rst_strobes", {o_selectLatch, o_outputA, o_outputB, o_latchC}, 0);
      check("rst_drive", o_bus_drive, 0);
      check("rst_bus", o_bus_data, 0);
      check("rst_result", o_result, 0);
      check("rst_state", dbg_state, 0);
`ifdef ARGON_SEQ_FLAGS_EN
      check("rst_flags", flags, 0);
`endif
      rst_n = 1'b1;

      issue(4'd1, 4'd2, 4'd3, F_ADD, 16'h000C, 4'b0000, 1, t);
      issue(4'd6, 4'd7, 4'd5, F_SUB, 16'hFFFF, 4'b0110, 1, t);
      issue(4'd8, 4'd9, 4'd13, F_SHL, 16'h0010, 4'b0000, 1, t);
      issue(4'd8, 4'd10, 4'd14, F_SHR, 16'h0001, 4'b0000, 1, t);
      issue(4'd8, 4'd7, 4'd13, F_SHL, 16'h0002, 4'b0010, 1, t);

      // valid held high across three ops with scrambled fields while busy
      hold = 1'b1;
      issue(4'd11, 4'd12, 4'd3, F_AND, 16'h00F0, 4'b0000, 1, a0);
      issue(4'd12, 4'd11, 4'd13, F_OR, 16'hFFF0, 4'b0100, 1, a1);
      hold = 1'b0;
      issue(4'd11, 4'd12, 4'd14, F_XOR, 16'hFF00, 4'b0100, 1, a2);
      check("b2b_gap_1", a1 - a0, 6);
      check("b2b_gap_2", a2 - a1, 6);

      // reset during RDB aborts the op
      issue(4'd1, 4'd2, 4'd9, F_ADD, 16'h0000, 4'b0000, 0, t);
      k = 0;
      while (!o_outputB && k < 10) begin
         @(negedge clk);
         k++;
      end
      if (!o_outputB) note_fail("rdb_timeout");
      rst_n = 1'b0;
      #1;
      check("abort_strobes", {o_selectLatch, o_outputA, o_outputB, o_latchC}, 0);
      check("abort_drive", o_bus_drive, 0);
      check("abort_bus", o_bus_data, 0);
      check("abort_result", o_result, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_ready", o_op_ready, 1);
      issue(4'd1, 4'd2, 4'd3, F_SUB, 16'hFFFE, 4'b0110, 1, t);

      // r0 as destination and as source
      issue(4'd4, 4'd0, 4'd0, F_PASS, 16'hBEEF, 4'b0100, 1, t);
      issue(4'd0, 4'd0, 4'd5, F_ADD, 16'h0000, 4'b1000, 1, t);
      issue(4'd8, 4'd8, 4'd6, F_ADD, 16'h0002, 4'b0011, 1, t);
      issue(4'd1, 4'd1, 4'd1, F_ADD, 16'h000A, 4'b0000, 1, t);
      issue(4'd1, 4'd7, 4'd4, F_ADD, 16'h000B, 4'b0000, 1, t);

      k = 0;
      while (exp_q.size() != 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (exp_q.size() != 0) note_fail("drain_timeout");
      repeat (3) @(negedge clk);
      check("sel_queue_empty", exp_sel_q.size(), 0);
      check("wr_queue_empty", exp_wr_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/argon_regfile_seq.md
Name: argon_regfile_seq

Overview:
- Micro-sequencer that executes one three-register ALU operation (rc = ra FUNC rb) by driving the register file's four control strobes and the shared 16-bit data bus.
- Accepts operations over a valid/ready handshake.
- Sequences the phases in order: index select, read A, read B, execute, write-back.
- Reports completion with a one-cycle done pulse and the result.

Parameters:
- WIDTH, 16, data/bus width in bits.
- IDX_W, 4, register index width; the index word packs ra at [3:0], rb at [7:4], rc at [11:8].

Ports:
- i_Clk  in  1  system clock, rising edge.
- i_Reset_n  in  1  asynchronous active-low reset.
- i_op_valid  in  1  operation request.
- o_op_ready  out  1  sequencer idle, can accept.
- i_op_ra  in  IDX_W  source A index.
- i_op_rb  in  IDX_W  source B index.
- i_op_rc  in  IDX_W  destination index.
- i_op_func  in  3  ALU function.
- o_done  out  1  one-cycle completion pulse.
- o_result  out  WIDTH  result of the last completed operation.
- o_selectLatch  out  1  regfile index-latch strobe.
- o_outputA  out  1  regfile drive-A strobe.
- o_outputB  out  1  regfile drive-B strobe.
- o_latchC  out  1  regfile write-C strobe.
- o_bus_drive  out  1  sequencer owns the bus this cycle.
- o_bus_data  out  WIDTH  data driven onto the bus; 0 when o_bus_drive=0.
- i_bus_data  in  WIDTH  bus read data from the regfile.

Behaviour:
- Reset (async, i_Reset_n=0):
  - state=IDLE.
  - o_done, all strobes, o_bus_drive, o_bus_data, o_result, and the operand and function registers are all 0.
  - Reset mid-operation aborts immediately; no o_latchC is ever issued after reset asserts.
- States: IDLE -> SEL -> RDA -> RDB -> CAPB -> WR -> IDLE; each non-IDLE state lasts exactly one cycle.
- Handshake:
  - o_op_ready=1 only in IDLE.
  - Accept on a rising edge with i_op_valid & o_op_ready.
  - ra, rb, rc and func are captured at accept; later input changes are ignored.
  - i_op_valid while busy is ignored and does not queue.
- Per-state outputs; all strobes are combinational from state and mutually exclusive:
  - SEL: o_selectLatch=1, o_bus_drive=1, o_bus_data={0, rc, rb, ra}.
  - RDA: o_outputA=1. The regfile registers A onto the bus at the end of this cycle.
  - RDB: o_outputB=1. Capture opA<=i_bus_data at the end of this cycle.
  - CAPB: capture opB<=i_bus_data at the end of this cycle; no strobes.
  - WR: o_latchC=1, o_bus_drive=1, o_bus_data=ALU(opA, opB, func). Register o_result<=that value and o_done<=1 at the end of the cycle.
- o_done is high for exactly the first IDLE cycle after WR.
- o_result holds its value until the next WR.
- Latency: accept edge to o_done high = 6 cycles; back-to-back throughput is one op per 6 cycles (new accept allowed in the o_done cycle).
- ALU functions, results truncated to WIDTH (modular):
  - 0 ADD
  - 1 SUB (A-B)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SHL by opB[3:0]
  - 6 SHR (logical) by opB[3:0]
  - 7 PASS A
- Register 0:
  - The sequencer does not special-case r0.
  - o_latchC is still issued with rc=0; the regfile discards the write.
  - Reads of r0 return 0 from the regfile.
  - o_result still reports the computed value.
- ra=rb and rc=ra/rb are legal: operands are captured before WR, so the write does not affect the current op.

Optional Feature:
- Macro ARGON_SEQ_FLAGS_EN.
- Defined:
  - Adds port o_flags (out, 4) = {Z, N, C, V}, registered alongside o_result in WR and reset to 0.
  - Z = result==0; N = result[WIDTH-1].
  - C = carry out for ADD, borrow (A<B unsigned) for SUB, last bit shifted out for SHL/SHR, 0 otherwise.
  - V = signed overflow for ADD/SUB, 0 otherwise.
- Undefined: port and flag logic absent; all other behaviour identical.

Test Plan:
- Reset then accept ra=1, rb=2, rc=3, func=ADD; bench regfile r1=0x0005, r2=0x0007 -> SEL bus=0x0321; o_latchC with bus=0x000C in cycle 5; o_done cycle 6, o_result=0x000C.
- SUB with A=0x0000, B=0x0001 -> o_result=0xFFFF; with flags: Z=0, N=1, C=1, V=0.
- SHL with A=0x8001, B=0x0004 -> 0x0010. SHR with A=0x8001, B=0x000F -> 0x0001.
- Hold i_op_valid high for 3 ops with changing fields mid-op -> exactly 3 accepts, 6 cycles apart; each op uses the fields sampled at its accept edge.
- Deassert i_Reset_n during RDB -> all strobes 0 immediately; no o_latchC; o_op_ready=1 after release; next op completes normally.
- rc=0, func=PASS, ra=4 (r4=0xBEEF) -> o_latchC issued with bus=0xBEEF; regfile r0 still reads 0; o_result=0xBEEF.
